dec_ctrl: RTL and testbench
===========================

# dec_ctrl

Request sequencer for the `DEC` codeword decoder. It accepts one codeword and mode per valid/ready handshake and drives `DEC` with held, registered inputs. It waits out the decoder pipeline, captures the decoded word and error count, and returns them on a valid/ready response channel. It sits between the bus-side register logic and `DEC`, so `DEC` never sees an input or mode change mid-decode.

## Interface
Parameters:
- `MAX_CODEWORD_WIDTH`, 32: codeword width; legal values 8, 16, 32.
- `MAX_INFO_WIDTH`, 26: passed through for consistency with `DEC`.
- `AMBA_WORD`, 32: width of `dec_work_mod`.
- `DEC_LATENCY`, 2: clock edges from a `DEC` input change to valid `DEC` outputs; minimum 1.
- `CNT_WIDTH`, 16: width of the statistics counters.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: controller can accept a request.
- `req_data`, in, MAX_CODEWORD_WIDTH: received codeword.
- `req_mode`, in, 2: 0 = (8,4), 1 = (16,11), 2 = (32,26); 3 is illegal.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_data`, out, MAX_CODEWORD_WIDTH: decoded info word, zero-padded as produced by `DEC`.
- `rsp_errors`, out, 2: 0 = none, 1 = single error corrected, 2 = double error detected.
- `rsp_illegal`, out, 1: request had an unsupported mode.
- `dec_data_in`, out, MAX_CODEWORD_WIDTH: drives `DEC.data_in`.
- `dec_work_mod`, out, AMBA_WORD: drives `DEC.work_mod` as the zero-extended mode.
- `dec_data_out`, in, MAX_CODEWORD_WIDTH: from `DEC.data_out`.
- `dec_num_of_errors`, in, 2: from `DEC.num_of_errors`.
- `cnt_clear`, in, 1: synchronous clear of the counters (present only under the macro).
- `cnt_single`, out, CNT_WIDTH: count of responses with error count 1 (present only under the macro).
- `cnt_double`, out, CNT_WIDTH: count of responses with error count 2 (present only under the macro).

## Operation
- FSM states are IDLE, WAIT and RESP; reset state is IDLE.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid` with a legal mode: register `req_data` into `dec_data_in` and the mode into `dec_work_mod`, load the wait counter with `DEC_LATENCY`, and go to WAIT.
  - On `req_valid` with an illegal mode: load `rsp_data` = 0, `rsp_errors` = 0, `rsp_illegal` = 1, and go to RESP. `dec_*` outputs are unchanged.
- Mode legality:
  - MAX_CODEWORD_WIDTH = 8: mode 0 only.
  - MAX_CODEWORD_WIDTH = 16: modes 0 and 1.
  - MAX_CODEWORD_WIDTH = 32: modes 0, 1 and 2.
  - Mode 3 is always illegal.
- **WAIT**
  - `req_ready` = 0; the counter decrements each cycle.
  - When the counter is 0, capture `dec_data_out` into `rsp_data`, `dec_num_of_errors` into `rsp_errors`, and `rsp_illegal` = 0, then go to RESP.
- **RESP**
  - `rsp_valid` = 1; response outputs are held stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- `dec_data_in` and `dec_work_mod` hold their last values in every state; they change only at a legal acceptance.
- A `dec_num_of_errors` value of 3 is passed through unchanged and not counted.

## Timing
- Reset values: all outputs 0; FSM in IDLE, so `req_ready` = 1 once `rst` deasserts.
- Let the legal acceptance edge be E0:
  - `dec_*` outputs update at E0.
  - Capture happens at E0 + DEC_LATENCY + 1.
  - `rsp_valid` is high from that edge onward.
- Illegal request: `rsp_valid` is high from E0 + 1.
- Throughput: at most one request per DEC_LATENCY + 3 cycles when `rsp_ready` is held at 1.
- `rst` asserted mid-operation: FSM returns immediately to IDLE and all outputs and counters go to 0. The in-flight request is dropped with no response.
- `rsp_ready` held low keeps the FSM in RESP indefinitely with outputs stable.

## Configuration
- Macro `DEC_CTRL_STATS_EN`.
- When defined:
  - `cnt_clear`, `cnt_single` and `cnt_double` exist.
  - The matching counter increments at the capture edge (WAIT to RESP) and saturates at all-ones.
  - `cnt_clear` takes priority over a same-cycle increment; that increment is lost.
- When undefined: these ports and counters are absent, and the rest of the behaviour is identical.

## Test plan
- Reset release with `req_valid` = 0 → all outputs 0, `req_ready` = 1, `dec_work_mod` = 0.
- Mode 2, `req_data` = 0x12345678, `rsp_ready` = 1, `DEC` model returning 0x00ABCDEF with error count 1:
  - `dec_work_mod` = 2 from E0.
  - At E0 + 3: `rsp_valid` = 1, `rsp_data` = 0x00ABCDEF, `rsp_errors` = 1.
  - `cnt_single` = 1 (macro on).
- Mode 3 request → `rsp_illegal` = 1 at E0 + 1, `rsp_data` = 0, `dec_*` unchanged, counters unchanged.
- `rsp_ready` held low for 10 cycles in RESP → response stable, `req_ready` = 0, a second `req_valid` is ignored; after the handshake, `req_ready` = 1 on the next cycle.
- `rst` pulsed low during WAIT → FSM in IDLE, no `rsp_valid`, counters 0; the next request completes normally.
- `CNT_WIDTH` = 2 with five double-error responses → `cnt_double` saturates at 3. A `cnt_clear` coincident with a capture → `cnt_double` = 0.

Source files
------------

// File: rtl/dec_ctrl.sv
// dec_ctrl: request sequencer in front of the DEC codeword decoder.
// Accepts one codeword and mode per request handshake and drives DEC with
// held, registered inputs. It waits out the DEC pipeline, then returns the
// captured decoded word and error count on a response handshake.
// Optional statistics counters are built when DEC_CTRL_STATS_EN is defined.
module dec_ctrl #(
   parameter int MAX_CODEWORD_WIDTH = 32,
   parameter int MAX_INFO_WIDTH     = 26,
   parameter int AMBA_WORD          = 32,
   parameter int DEC_LATENCY        = 2,
   parameter int CNT_WIDTH          = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [MAX_CODEWORD_WIDTH-1:0] req_data,
   input  logic [1:0]                    req_mode,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [MAX_CODEWORD_WIDTH-1:0] rsp_data,
   output logic [1:0]                    rsp_errors,
   output logic                          rsp_illegal,
   output logic [MAX_CODEWORD_WIDTH-1:0] dec_data_in,
   output logic [AMBA_WORD-1:0]          dec_work_mod,
   input  logic [MAX_CODEWORD_WIDTH-1:0] dec_data_out,
   input  logic [1:0]                    dec_num_of_errors
`ifdef DEC_CTRL_STATS_EN
   ,
   input  logic                          cnt_clear,
   output logic [CNT_WIDTH-1:0]          cnt_single,
   output logic [CNT_WIDTH-1:0]          cnt_double
`endif
);

   localparam int WAIT_W = $clog2(DEC_LATENCY + 1);

   // Reject parameter sets the controller cannot serve.
   if (!(MAX_CODEWORD_WIDTH == 8 || MAX_CODEWORD_WIDTH == 16 || MAX_CODEWORD_WIDTH == 32))
   begin : g_bad_width
      $error("dec_ctrl: MAX_CODEWORD_WIDTH must be 8, 16 or 32");
   end
   if (DEC_LATENCY < 1 || AMBA_WORD < 2 || CNT_WIDTH < 1 || MAX_INFO_WIDTH > MAX_CODEWORD_WIDTH)
   begin : g_bad_params
      $error("dec_ctrl: inconsistent DEC_LATENCY/AMBA_WORD/CNT_WIDTH/MAX_INFO_WIDTH");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WAIT_W-1:0] wait_cnt;
   logic [1:0]        mode_q;
   logic              accept;
   logic              load_illegal;
   logic              capture;

   // A mode is legal only if the configured codeword width can hold it.
   function automatic logic mode_legal(input logic [1:0] m);
      case (m)
         2'd0:    return 1'b1;
         2'd1:    return (MAX_CODEWORD_WIDTH >= 16);
         2'd2:    return (MAX_CODEWORD_WIDTH >= 32);
         default: return 1'b0;
      endcase
   endfunction

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic, handshake outputs and datapath load strobes.
   always_comb begin
      state_nxt    = state;
      req_ready    = 1'b0;
      rsp_valid    = 1'b0;
      accept       = 1'b0;
      load_illegal = 1'b0;
      capture      = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (mode_legal(req_mode)) begin
                  accept    = 1'b1;
                  state_nxt = WAIT;
               end else begin
                  load_illegal = 1'b1;
                  state_nxt    = RESP;
               end
            end
         end
         WAIT: begin
            if (wait_cnt == '0) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Wait counter: loaded at acceptance, counts down to the capture cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= '0;
      end else if (accept) begin
         wait_cnt <= WAIT_W'(DEC_LATENCY);
      end else if (state == WAIT && wait_cnt != '0) begin
         wait_cnt <= wait_cnt - WAIT_W'(1);
      end
   end

   // DEC inputs: held between legal acceptances so DEC never sees a change mid-decode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dec_data_in <= '0;
         mode_q      <= '0;
      end else if (accept) begin
         dec_data_in <= req_data;
         mode_q      <= req_mode;
      end
   end

   assign dec_work_mod = AMBA_WORD'(mode_q);

   // Response registers: loaded on illegal request or at the capture cycle, held in RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_data    <= '0;
         rsp_errors  <= '0;
         rsp_illegal <= 1'b0;
      end else if (load_illegal) begin
         rsp_data    <= '0;
         rsp_errors  <= '0;
         rsp_illegal <= 1'b1;
      end else if (capture) begin
         rsp_data    <= dec_data_out;
         rsp_errors  <= dec_num_of_errors;
         rsp_illegal <= 1'b0;
      end
   end

`ifdef DEC_CTRL_STATS_EN
   // Saturating increment: sticks at all-ones.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   // Error statistics; clear wins over a same-cycle increment, error count 3 is not counted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_single <= '0;
         cnt_double <= '0;
      end else if (cnt_clear) begin
         cnt_single <= '0;
         cnt_double <= '0;
      end else if (capture) begin
         if (dec_num_of_errors == 2'd1) cnt_single <= sat_inc(cnt_single);
         if (dec_num_of_errors == 2'd2) cnt_double <= sat_inc(cnt_double);
      end
   end
`endif

endmodule

// File: tb/tb_dec_ctrl.sv
// Testbench for dec_ctrl: directed and randomized requests against a
// behavioural DEC model and a transaction-level reference model.
module tb_dec_ctrl;

   localparam int W   = 32;
   localparam int AW  = 32;
   localparam int L   = 2;
   localparam int CW  = 2;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [W-1:0]  req_data;
   logic [1:0]    req_mode;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_data;
   logic [1:0]    rsp_errors;
   logic          rsp_illegal;
   logic [W-1:0]  dec_data_in;
   logic [AW-1:0] dec_work_mod;
   logic [W-1:0]  dec_data_out;
   logic [1:0]    dec_num_of_errors;
`ifdef DEC_CTRL_STATS_EN
   logic          cnt_clear;
   logic [CW-1:0] cnt_single;
   logic [CW-1:0] cnt_double;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   dec_ctrl #(
      .MAX_CODEWORD_WIDTH(W),
      .MAX_INFO_WIDTH(26),
      .AMBA_WORD(AW),
      .DEC_LATENCY(L),
      .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_data(req_data),
      .req_mode(req_mode),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data(rsp_data),
      .rsp_errors(rsp_errors),
      .rsp_illegal(rsp_illegal),
      .dec_data_in(dec_data_in),
      .dec_work_mod(dec_work_mod),
      .dec_data_out(dec_data_out),
      .dec_num_of_errors(dec_num_of_errors)
`ifdef DEC_CTRL_STATS_EN
      ,
      .cnt_clear(cnt_clear),
      .cnt_single(cnt_single),
      .cnt_double(cnt_double)
`endif
   );

   always #5 clk = ~clk;

   // DEC model: the programmed result appears only after L rising edges
   // with unchanged inputs; until then it returns a recognisable junk value.
   logic [W-1:0]  dec_word;
   logic [1:0]    dec_err;
   logic [W-1:0]  prev_in;
   logic [AW-1:0] prev_mod;
   int            age = 0;

   always @(negedge clk) begin
      if (dec_data_in !== prev_in || dec_work_mod !== prev_mod) begin
         age      = 0;
         prev_in  = dec_data_in;
         prev_mod = dec_work_mod;
      end else if (age < L) begin
         age = age + 1;
      end
      if (age >= L) begin
         dec_data_out      = dec_word;
         dec_num_of_errors = dec_err;
      end else begin
         dec_data_out      = 32'hDEAD_BEEF;
         dec_num_of_errors = 2'd3;
      end
   end

   // Reference state: expected DEC drive and error tallies since last clear.
   logic [W-1:0]  exp_dec_in;
   logic [AW-1:0] exp_dec_mod;
   int            n_single;
   int            n_double;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_counters(input string tag);
`ifdef DEC_CTRL_STATS_EN
      check({tag, "_cnt_single"}, 64'(cnt_single), 64'((n_single > CNT_MAX) ? CNT_MAX : n_single));
      check({tag, "_cnt_double"}, 64'(cnt_double), 64'((n_double > CNT_MAX) ? CNT_MAX : n_double));
`else
      check({tag, "_no_stats_illegal_low"}, 64'(rsp_illegal & ~rsp_valid), 64'd0);
`endif
   endtask

   // One full request/response transaction.
   task automatic txn(input logic [W-1:0] data, input logic [1:0] mode,
                      input logic [W-1:0] word, input logic [1:0] err,
                      input int hold, input bit clr);
      bit legal;
      int n;
      legal    = (mode != 2'd3);
      dec_word = word;
      dec_err  = err;
      @(negedge clk);
      check("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_data  = data;
      req_mode  = mode;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_data  = $urandom;
      if (legal) begin
         exp_dec_in  = data;
         exp_dec_mod = AW'(mode);
      end
      check("dec_data_in_e0", 64'(dec_data_in), 64'(exp_dec_in));
      check("dec_work_mod_e0", 64'(dec_work_mod), 64'(exp_dec_mod));
      check("req_ready_busy", 64'(req_ready), 64'd0);
      if (legal) begin
         check("rsp_valid_early", 64'(rsp_valid), 64'd0);
         n = 0;
         while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
`ifdef DEC_CTRL_STATS_EN
            cnt_clear = 1'b0;
`endif
            if (rsp_valid) break;
`ifdef DEC_CTRL_STATS_EN
            if (clr && n == L) cnt_clear = 1'b1;
`endif
         end
         check("capture_latency", 64'(n), 64'(L + 1));
         if (clr) begin
            n_single = 0;
            n_double = 0;
         end else if (err == 2'd1) begin
            n_single++;
         end else if (err == 2'd2) begin
            n_double++;
         end
      end else begin
         @(posedge clk);
         #1;
         check("illegal_rsp_valid", 64'(rsp_valid), 64'd1);
      end
      check("rsp_data", 64'(rsp_data), legal ? 64'(word) : 64'd0);
      check("rsp_errors", 64'(rsp_errors), legal ? 64'(err) : 64'd0);
      check("rsp_illegal", 64'(rsp_illegal), legal ? 64'd0 : 64'd1);
      check_counters("capture");
      for (int k = 0; k < hold; k++) begin
         req_valid = 1'b1;
         req_data  = $urandom;
         req_mode  = 2'd0;
         @(posedge clk);
         #1;
         check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
         check("stall_rsp_data", 64'(rsp_data), legal ? 64'(word) : 64'd0);
         check("stall_req_ready", 64'(req_ready), 64'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
      check("post_hs_req_ready", 64'(req_ready), 64'd1);
      check("post_hs_dec_data_in", 64'(dec_data_in), 64'(exp_dec_in));
   endtask

   initial begin
      int any_valid;
      rst       = 1'b0;
      req_valid = 1'b0;
      req_data  = '0;
      req_mode  = '0;
      rsp_ready = 1'b0;
      dec_word  = '0;
      dec_err   = '0;
`ifdef DEC_CTRL_STATS_EN
      cnt_clear = 1'b0;
`endif
      exp_dec_in  = '0;
      exp_dec_mod = '0;
      n_single    = 0;
      n_double    = 0;

      // Reset release with no request pending.
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_data", 64'(rsp_data), 64'd0);
      check("rst_rsp_errors", 64'(rsp_errors), 64'd0);
      check("rst_rsp_illegal", 64'(rsp_illegal), 64'd0);
      check("rst_dec_data_in", 64'(dec_data_in), 64'd0);
      check("rst_dec_work_mod", 64'(dec_work_mod), 64'd0);
      check_counters("rst");

      // Mode 2 single-error decode.
      txn(32'h1234_5678, 2'd2, 32'h00AB_CDEF, 2'd1, 0, 1'b0);

      // Illegal mode with the consumer stalled for 10 cycles.
      txn($urandom, 2'd3, $urandom, 2'd1, 10, 1'b0);

      // Five double errors drive the 2-bit counter into saturation.
      for (int i = 0; i < 5; i++) begin
         txn($urandom, 2'($urandom_range(0, 2)), $urandom, 2'd2, 0, 1'b0);
      end

      // Counter clear coincident with a double-error capture.
      txn($urandom, 2'd1, $urandom, 2'd2, 1, 1'b1);

      // Reset pulsed during WAIT drops the request.
      dec_word = 32'h0000_0777;
      dec_err  = 2'd1;
      @(negedge clk);
      req_valid = 1'b1;
      req_data  = 32'hCAFE_F00D;
      req_mode  = 2'd1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("midwait_dec_work_mod", 64'(dec_work_mod), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      exp_dec_in  = '0;
      exp_dec_mod = '0;
      n_single    = 0;
      n_double    = 0;
      check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("midrst_dec_data_in", 64'(dec_data_in), 64'd0);
      check("midrst_dec_work_mod", 64'(dec_work_mod), 64'd0);
      check_counters("midrst");
      @(negedge clk);
      rst = 1'b1;
      any_valid = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (rsp_valid) any_valid = 1;
      end
      check("midrst_no_response", 64'(any_valid), 64'd0);
      txn(32'h0BAD_F00D, 2'd0, 32'h0000_000B, 2'd1, 0, 1'b0);

      // Randomized traffic, including illegal modes and error count 3.
      for (int i = 0; i < 16; i++) begin
         txn($urandom, 2'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)),
             $urandom_range(0, 3), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
